// File: rtl/pipe_pkg.sv
// Shared constants and payload types for the inter-stage pipeline register.
package pipe_pkg;

    localparam int unsigned EXC_W        = 5;
    localparam int unsigned ENTRY_DATA_W = 32;
    localparam int unsigned ENTRY_PC_W   = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    typedef logic [EXC_W-1:0] exccode_t;

    // Canonical stage-boundary payload at the default widths
    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] instr;
        logic [ENTRY_PC_W-1:0]   pc;
        exccode_t                exccode;
        logic                    bd;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One pipeline entry register (payload plus valid bit) with load, clear and PC redirect.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     DATA_W   = 32,
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic [DATA_W-1:0] instr_d,
    input  logic [PC_W-1:0]   pc_d,
    input  exccode_t          exccode_d,
    input  logic              bd_d,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   pc,
    output exccode_t          exccode,
    output logic              bd
);

    // Clear zeroes the payload but keeps the PC unless a redirect is requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            instr   <= '0;
            pc      <= RESET_PC;
            exccode <= '0;
            bd      <= 1'b0;
        end else if (clear) begin
            valid   <= 1'b0;
            instr   <= '0;
            exccode <= '0;
            bd      <= 1'b0;
            if (redirect) begin
                pc <= redirect_pc;
            end
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= instr_d;
            pc      <= pc_d;
            exccode <= exccode_d;
            bd      <= bd_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a two-entry skid buffer.
// Optional feature macro: PIPE_STAGE_EXC_EN (exception code / BD propagation and Req redirect).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     DATA_W   = 32,
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF),
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instrIn,
    input  logic [PC_W-1:0]   PCIn,
    input  logic [EXC_W-1:0]  ExcCodeIn,
    input  logic              BDIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instrOut,
    output logic [PC_W-1:0]   PCOut,
    output logic [EXC_W-1:0]  ExcCodeOut,
    output logic              BDOut,
    output logic [CNT_W-1:0]  stall_cnt
);

    exccode_t in_exccode;
    logic     in_bd;
    logic     exc_redirect;

`ifdef PIPE_STAGE_EXC_EN
    assign in_exccode   = ExcCodeIn;
    assign in_bd        = BDIn;
    assign exc_redirect = Req;
`else
    // Exception fields are never stored, so the outputs stay at zero and Req acts as flush
    logic unused_exc_inputs;
    assign unused_exc_inputs = ^{ExcCodeIn, BDIn};
    assign in_exccode   = '0;
    assign in_bd        = 1'b0;
    assign exc_redirect = 1'b0;
`endif

    logic              main_valid;
    logic              skid_valid;
    logic              ready_q;
    logic [DATA_W-1:0] skid_instr;
    logic [PC_W-1:0]   skid_pc;
    exccode_t          skid_exccode;
    logic              skid_bd;

    logic              kill;
    logic              accept;
    logic              drain;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid_nxt;
    logic [DATA_W-1:0] main_instr_d;
    logic [PC_W-1:0]   main_pc_d;
    exccode_t          main_exccode_d;
    logic              main_bd_d;

    assign kill   = Req || flush;
    assign accept = in_valid && ready_q;
    assign drain  = main_valid && out_ready;

    // Entry movement: skid refills main first; new data lands in main if it frees up, else in skid
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        skid_valid_nxt = skid_valid;
        if (kill) begin
            main_clear     = 1'b1;
            skid_clear     = 1'b1;
            skid_valid_nxt = 1'b0;
        end else begin
            if (drain && skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clear     = 1'b1;
                skid_valid_nxt = 1'b0;
            end else if (accept && (!main_valid || drain)) begin
                main_load = 1'b1;
            end else if (drain) begin
                main_clear = 1'b1;
            end
            if (accept && main_valid && !drain) begin
                skid_load      = 1'b1;
                skid_valid_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        main_instr_d   = instrIn;
        main_pc_d      = PCIn;
        main_exccode_d = in_exccode;
        main_bd_d      = in_bd;
        if (main_from_skid) begin
            main_instr_d   = skid_instr;
            main_pc_d      = skid_pc;
            main_exccode_d = skid_exccode;
            main_bd_d      = skid_bd;
        end
    end

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_main (
        .clk         (clk),
        .rst         (reset),
        .load        (main_load),
        .clear       (main_clear),
        .redirect    (exc_redirect),
        .redirect_pc (EXC_VEC),
        .instr_d     (main_instr_d),
        .pc_d        (main_pc_d),
        .exccode_d   (main_exccode_d),
        .bd_d        (main_bd_d),
        .valid       (main_valid),
        .instr       (instrOut),
        .pc          (PCOut),
        .exccode     (ExcCodeOut),
        .bd          (BDOut)
    );

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk         (clk),
        .rst         (reset),
        .load        (skid_load),
        .clear       (skid_clear),
        .redirect    (1'b0),
        .redirect_pc (RESET_PC),
        .instr_d     (instrIn),
        .pc_d        (PCIn),
        .exccode_d   (in_exccode),
        .bd_d        (in_bd),
        .valid       (skid_valid),
        .instr       (skid_instr),
        .pc          (skid_pc),
        .exccode     (skid_exccode),
        .bd          (skid_bd)
    );

    // in_ready is registered from the next skid state, so out_ready never reaches it combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= !skid_valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a drain-side scoreboard.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned CNT_W  = 4;
`ifdef PIPE_STAGE_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              Req;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] instrIn;
    logic [PC_W-1:0]   PCIn;
    logic [EXC_W-1:0]  ExcCodeIn;
    logic              BDIn;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] instrOut;
    logic [PC_W-1:0]   PCOut;
    logic [EXC_W-1:0]  ExcCodeOut;
    logic              BDOut;
    logic [CNT_W-1:0]  stall_cnt;

    int total = 0;
    int bad   = 0;
    pipe_entry_t sb[$];
    pipe_entry_t exp_e;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Req        (Req),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instrIn    (instrIn),
        .PCIn       (PCIn),
        .ExcCodeIn  (ExcCodeIn),
        .BDIn       (BDIn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instrOut   (instrOut),
        .PCOut      (PCOut),
        .ExcCodeOut (ExcCodeOut),
        .BDOut      (BDOut),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic pipe_entry_t make_entry(input logic [31:0] pc);
        pipe_entry_t e;
        e.instr   = pc ^ 32'hC0DE_0000;
        e.pc      = pc;
        e.exccode = exccode_t'(pc[6:2] ^ 5'h11);
        e.bd      = ~pc[2];
        return e;
    endfunction

    function automatic pipe_entry_t expect_of(input pipe_entry_t e);
        pipe_entry_t r;
        r = e;
        if (!EXC_EN) begin
            r.exccode = '0;
            r.bd      = 1'b0;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input bit push);
        pipe_entry_t e;
        e = make_entry(pc);
        in_valid  = 1'b1;
        instrIn   = e.instr;
        PCIn      = e.pc;
        ExcCodeIn = e.exccode;
        BDIn      = e.bd;
        if (push) sb.push_back(expect_of(e));
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        Req = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        sb.delete();
    endtask

    // Scoreboard: every handshake-completed drain must match the oldest accepted entry
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !Req && !flush) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL drain_unexpected: got pc=%h, required no output", PCOut);
            end else begin
                exp_e = sb.pop_front();
                if ({instrOut, PCOut, ExcCodeOut, BDOut} !==
                    {exp_e.instr, exp_e.pc, exp_e.exccode, exp_e.bd}) begin
                    bad++;
                    $display("FAIL drain_data: got instr=%h pc=%h exc=%h bd=%b, required instr=%h pc=%h exc=%h bd=%b",
                             instrOut, PCOut, ExcCodeOut, BDOut,
                             exp_e.instr, exp_e.pc, exp_e.exccode, exp_e.bd);
                end
            end
        end
    end

    task automatic test_reset;
        do_reset;
        send(32'h3100, 1'b1);
        tick;
        in_valid = 1'b0;
        tick;
        #2;
        reset = 1'b1;
        #1;
        total++; if (PCOut !== 32'h3000) begin bad++; $display("FAIL reset_pc: got %h required %h", PCOut, 32'h3000); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt); end
        total++; if (instrOut !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h required 0", instrOut); end
        sb.delete();
        tick;
        reset = 1'b0;
    endtask

    task automatic test_stream;
        logic [31:0] pc;
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            send(pc, 1'b1);
            tick;
            total++; if (out_valid !== 1'b1 || PCOut !== pc) begin bad++; $display("FAIL stream_latency[%0d]: got valid=%b pc=%h required valid=1 pc=%h", i, out_valid, PCOut, pc); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b required 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick;
        total++; if (out_valid !== 1'b0 || instrOut !== 32'h0 || PCOut !== 32'h300C) begin bad++; $display("FAIL stream_empty: got valid=%b instr=%h pc=%h required valid=0 instr=0 pc=0000300c", out_valid, instrOut, PCOut); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_sb_empty: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_skid;
        do_reset;
        send(32'h3000, 1'b1);
        tick;
        total++; if (in_ready !== 1'b1 || stall_cnt !== 4'd0) begin bad++; $display("FAIL skid_first: got ready=%b cnt=%0d required ready=1 cnt=0", in_ready, stall_cnt); end
        send(32'h3004, 1'b1);
        tick;
        total++; if (in_ready !== 1'b0 || PCOut !== 32'h3000 || stall_cnt !== 4'd1) begin bad++; $display("FAIL skid_full: got ready=%b pc=%h cnt=%0d required ready=0 pc=00003000 cnt=1", in_ready, PCOut, stall_cnt); end
        send(32'h3008, 1'b0);
        tick;
        tick;
        total++; if (in_ready !== 1'b0 || PCOut !== 32'h3000 || stall_cnt !== 4'd3) begin bad++; $display("FAIL skid_hold: got ready=%b pc=%h cnt=%0d required ready=0 pc=00003000 cnt=3", in_ready, PCOut, stall_cnt); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        total++; if (in_ready !== 1'b1 || PCOut !== 32'h3004 || out_valid !== 1'b1) begin bad++; $display("FAIL skid_refill: got ready=%b pc=%h valid=%b required ready=1 pc=00003004 valid=1", in_ready, PCOut, out_valid); end
        tick;
        total++; if (out_valid !== 1'b0 || instrOut !== 32'h0 || PCOut !== 32'h3004 || stall_cnt !== 4'd3) begin bad++; $display("FAIL skid_drained: got valid=%b instr=%h pc=%h cnt=%0d required valid=0 instr=0 pc=00003004 cnt=3", out_valid, instrOut, PCOut, stall_cnt); end
    endtask

    task automatic test_exception;
        pipe_entry_t e;
        logic [31:0] pc_req;
        do_reset;
        e = expect_of(make_entry(32'h3000));
        send(32'h3000, 1'b1);
        tick;
        total++; if (ExcCodeOut !== e.exccode || BDOut !== e.bd) begin bad++; $display("FAIL exc_fields: got exc=%h bd=%b required exc=%h bd=%b", ExcCodeOut, BDOut, e.exccode, e.bd); end
        send(32'h3004, 1'b1);
        tick;
        send(32'h3008, 1'b0);
        Req = 1'b1;
        tick;
        Req = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        pc_req = EXC_EN ? 32'h4180 : 32'h3000;
        total++; if (out_valid !== 1'b0 || instrOut !== 32'h0 || ExcCodeOut !== 5'h0 || BDOut !== 1'b0) begin bad++; $display("FAIL exc_cleared: got valid=%b instr=%h exc=%h bd=%b required all 0", out_valid, instrOut, ExcCodeOut, BDOut); end
        total++; if (PCOut !== pc_req || in_ready !== 1'b1) begin bad++; $display("FAIL exc_redirect: got pc=%h ready=%b required pc=%h ready=1", PCOut, in_ready, pc_req); end
        send(32'h3010, 1'b1);
        tick;
        send(32'h3014, 1'b0);
        Req = 1'b1;
        tick;
        Req = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        tick;
        pc_req = EXC_EN ? 32'h4180 : 32'h3010;
        total++; if (out_valid !== 1'b0 || PCOut !== pc_req || in_ready !== 1'b1) begin bad++; $display("FAIL exc_drop_accept: got valid=%b pc=%h ready=%b required valid=0 pc=%h ready=1", out_valid, PCOut, in_ready, pc_req); end
    endtask

    task automatic test_flush;
        logic [31:0] pc_req;
        do_reset;
        out_ready = 1'b1;
        send(32'h3000, 1'b1);
        tick;
        send(32'h3004, 1'b1);
        tick;
        send(32'h3008, 1'b1);
        tick;
        out_ready = 1'b0;
        send(32'h300C, 1'b1);
        tick;
        total++; if (PCOut !== 32'h3008 || in_ready !== 1'b0) begin bad++; $display("FAIL flush_setup: got pc=%h ready=%b required pc=00003008 ready=0", PCOut, in_ready); end
        in_valid = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        sb.delete();
        total++; if (out_valid !== 1'b0 || instrOut !== 32'h0 || PCOut !== 32'h3008 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_keep_pc: got valid=%b instr=%h pc=%h ready=%b required valid=0 instr=0 pc=00003008 ready=1", out_valid, instrOut, PCOut, in_ready); end
        tick;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_skid_leak: got valid=%b required 0", out_valid); end
        send(32'h3010, 1'b1);
        tick;
        in_valid = 1'b0;
        flush = 1'b1;
        Req = 1'b1;
        tick;
        flush = 1'b0;
        Req = 1'b0;
        sb.delete();
        pc_req = EXC_EN ? 32'h4180 : 32'h3010;
        total++; if (out_valid !== 1'b0 || PCOut !== pc_req) begin bad++; $display("FAIL flush_req_priority: got valid=%b pc=%h required valid=0 pc=%h", out_valid, PCOut, pc_req); end
    endtask

    task automatic test_saturation;
        do_reset;
        send(32'h3000, 1'b1);
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        total++; if (stall_cnt !== 4'd10) begin bad++; $display("FAIL sat_mid: got %0d required 10", stall_cnt); end
        repeat (10) tick;
        total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_max: got %0d required 15", stall_cnt); end
        tick;
        total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d required 15", stall_cnt); end
        Req = 1'b1;
        tick;
        Req = 1'b0;
        sb.delete();
        tick;
        total++; if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin bad++; $display("FAIL sat_after_req: got cnt=%0d valid=%b required cnt=15 valid=0", stall_cnt, out_valid); end
    endtask

    task automatic test_random;
        int unsigned k;
        k = 0;
        do_reset;
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) begin
                send(32'h5000 + 32'(4 * k), 1'b0);
                if (in_ready) begin
                    sb.push_back(expect_of(make_entry(32'h5000 + 32'(4 * k))));
                    k++;
                end
            end else begin
                in_valid = 1'b0;
            end
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick;
        total++; if (sb.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL random_drained: got pending=%0d valid=%b required pending=0 valid=0", sb.size(), out_valid); end
    endtask

    initial begin
        reset     = 1'b1;
        Req       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instrIn   = '0;
        PCIn      = '0;
        ExcCodeIn = '0;
        BDIn      = 1'b0;
        tick;
        test_reset;
        test_stream;
        test_skid;
        test_exception;
        test_flush;
        test_saturation;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
